// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO result registers.
// Operands are latched on start; the result is committed on the edge where busy falls.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LAT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LAT  = CW'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] lat;
  logic [31:0]   op_a;
  logic [31:0]   op_b;
  logic [1:0]    op;
  logic          accept;
  logic          done;
  logic          is_div;
  logic          signed_op;

  logic [63:0]   mul_x;
  logic [63:0]   mul_y;
  logic [63:0]   product;
  logic [31:0]   mag_a;
  logic [31:0]   mag_b;
  logic [31:0]   div_b;
  logic [31:0]   quo_u;
  logic [31:0]   rem_u;
  logic [31:0]   quo;
  logic [31:0]   rem;
  logic          res_wr;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;

  assign is_div    = op[1];
  assign signed_op = ~op[0];
  assign lat       = is_div ? DIV_LAT : MULT_LAT;
  assign accept    = (state == IDLE) && start;
  assign done      = (state == RUN) && (cnt == lat);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (cnt == lat) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  // cnt counts busy cycles 1..lat, so busy lasts exactly lat cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      op_a <= '0;
      op_b <= '0;
      op   <= '0;
    end else if (accept) begin
      cnt  <= CW'(1);
      op_a <= a;
      op_b <= b;
      op   <= md_op;
    end else if (done) begin
      cnt  <= '0;
    end else if (state == RUN) begin
      cnt  <= cnt + CW'(1);
    end
  end

  // Division works on magnitudes, then restores signs: quotient truncates
  // toward zero and the remainder follows the dividend.
  always_comb begin
    mul_x   = signed_op ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
    mul_y   = signed_op ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
    product = mul_x * mul_y;

    mag_a = (signed_op && op_a[31]) ? (32'd0 - op_a) : op_a;
    mag_b = (signed_op && op_b[31]) ? (32'd0 - op_b) : op_b;
    div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
    quo_u = mag_a / div_b;
    rem_u = mag_a % div_b;
    quo   = (signed_op && (op_a[31] ^ op_b[31])) ? (32'd0 - quo_u) : quo_u;
    rem   = (signed_op && op_a[31]) ? (32'd0 - rem_u) : rem_u;

    res_wr = 1'b1;
    res_hi = product[63:32];
    res_lo = product[31:0];
    if (is_div) begin
      res_wr = (op_b != 32'd0);
      res_hi = rem;
      res_lo = quo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (done) begin
      if (res_wr) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else if ((state == IDLE) && !start) begin
      if (mthi) hi <= a;
      if (mtlo) lo <= a;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and randomized checks of md_unit against an arithmetic
// reference model of HI/LO and busy duration.
module tb_md_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  md_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the operands.
  task automatic modelOp(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic wr, output logic [31:0] mh, output logic [31:0] ml);
    longint      sx, sy, q, r;
    logic [63:0] p;
    wr = 1'b1; mh = 32'd0; ml = 32'd0;
    case (op)
      2'b00: begin
        p  = longint'($signed(x)) * longint'($signed(y));
        mh = p[63:32]; ml = p[31:0];
      end
      2'b01: begin
        p  = {32'd0, x} * {32'd0, y};
        mh = p[63:32]; ml = p[31:0];
      end
      default: begin
        if (y == 32'd0) begin
          wr = 1'b0;
        end else begin
          sx = (op == 2'b10) ? longint'($signed(x)) : longint'({32'd0, x});
          sy = (op == 2'b10) ? longint'($signed(y)) : longint'({32'd0, y});
          q  = sx / sy;
          r  = sx % sy;
          ml = q[31:0]; mh = r[31:0];
        end
      end
    endcase
  endtask

  // Called at a negedge; returns at the negedge after busy falls.
  // disturbAt > 0 pulses start/mthi/mtlo with junk on that busy cycle.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                               input int disturbAt, input logic withMt);
    int          n, cyc;
    logic        wr;
    logic [31:0] mh, ml;
    n = op[1] ? DIV_CYCLES : MULT_CYCLES;
    modelOp(op, x, y, wr, mh, ml);
    start = 1'b1; md_op = op; a = x; b = y; mthi = withMt; mtlo = withMt;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    a = $urandom; b = $urandom; md_op = 2'($urandom);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      checkOutput("hold_hi", hi, exp_hi);
      checkOutput("hold_lo", lo, exp_lo);
      if (cyc == disturbAt) begin
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; a = $urandom; b = $urandom;
      end else begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    checkOutput("busy_cycles", 32'(cyc), 32'(n));
    if (wr) begin
      exp_hi = mh;
      exp_lo = ml;
    end
    checkOutput("result_hi", hi, exp_hi);
    checkOutput("result_lo", lo, exp_lo);
  endtask

  task automatic mtWrite(input logic wh, input logic wl, input logic [31:0] v);
    mthi = wh; mtlo = wl; a = v; start = 1'b0;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    if (wh) exp_hi = v;
    if (wl) exp_lo = v;
    checkOutput("mt_hi", hi, exp_hi);
    checkOutput("mt_lo", lo, exp_lo);
    checkOutput("mt_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] rx, ry;

    // Reset wins over a simultaneous start and mthi/mtlo.
    reset = 1'b1; start = 1'b1; md_op = 2'b00; a = 32'hDEADBEEF; b = 32'd3;
    mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);

    applyStimulus(2'b00, 32'hFFFFFFFE, 32'd3, 0, 1'b0);
    checkOutput("mult_neg_hi", hi, 32'hFFFFFFFF);
    checkOutput("mult_neg_lo", lo, 32'hFFFFFFFA);

    applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
    checkOutput("multu_max_hi", hi, 32'hFFFFFFFE);
    checkOutput("multu_max_lo", lo, 32'h00000001);

    applyStimulus(2'b10, 32'hFFFFFFF9, 32'd2, 0, 1'b0);
    checkOutput("div_neg_hi", hi, 32'hFFFFFFFF);
    checkOutput("div_neg_lo", lo, 32'hFFFFFFFD);

    applyStimulus(2'b11, 32'd7, 32'd0, 0, 1'b0);
    checkOutput("divu_zero_hi", hi, 32'hFFFFFFFF);
    checkOutput("divu_zero_lo", lo, 32'hFFFFFFFD);

    mtWrite(1'b1, 1'b0, 32'h12345678);
    checkOutput("mthi_value", hi, 32'h12345678);
    mtWrite(1'b1, 1'b1, 32'hCAFEF00D);

    // Start pulse (with mthi/mtlo) in the 3rd busy cycle must be ignored.
    applyStimulus(2'b00, 32'd1000, 32'hFFFFFFF0, 3, 1'b0);
    checkOutput("ignored_start_hi", hi, 32'hFFFFFFFF);
    checkOutput("ignored_start_lo", lo, 32'hFFFFC180);

    applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
    checkOutput("div_ovf_hi", hi, 32'h00000000);
    checkOutput("div_ovf_lo", lo, 32'h80000000);

    // mthi/mtlo alongside an accepted start are dropped; also back-to-back start.
    applyStimulus(2'b11, 32'd100, 32'd7, 0, 1'b1);
    checkOutput("divu_hi", hi, 32'd2);
    checkOutput("divu_lo", lo, 32'd14);

    // Reset in the 4th busy cycle of a div aborts it with no result write.
    start = 1'b1; md_op = 2'b10; a = 32'd99; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    repeat (DIV_CYCLES + 2) @(negedge clk);
    checkOutput("abort_late_hi", hi, 32'd0);
    checkOutput("abort_late_lo", lo, 32'd0);
    checkOutput("abort_late_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom);
      rx  = $urandom;
      ry  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) ry = ry & 32'h0000000F;
      if ($urandom_range(0, 4) == 0)
        mtWrite(1'($urandom), 1'($urandom), $urandom);
      applyStimulus(rop, rx, ry, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0,
                    1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
